reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 114 +++++++++++
 tb/tb_reg_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks the in-flight writes to r1..r15 with 2-bit
// pending counters. It stalls decode on RAW hazards and when a counter is
// full, and counts stall cycles in a saturating counter.
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_wr,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rs,
  input  logic        id_rs_use,
  input  logic [3:0]  id_rt,
  input  logic        id_rt_use,
  input  logic        wb_regwrite,
  input  logic [3:0]  wb_rd,
  input  logic        x_kill,
  input  logic        x_wr,
  input  logic [3:0]  x_rd,
  output logic        stall,
  output logic        busy,
  output logic        err,
  output logic [15:0] stall_cnt
);

  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d [16];
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        issue;
  logic        wb_hit_rs, wb_hit_rt;
  logic        hazard_rs, hazard_rt, full_rd;
  logic        underflow;
  logic [15:0] nonzero;

  // Hazard detection. A WB to the source in the same cycle is written through
  // the register file, so one pending write is forgiven. The effective count
  // is clamped at zero: a stray WB never creates a hazard on an idle register.
  always_comb begin
    wb_hit_rs = wb_regwrite && (wb_rd == id_rs);
    wb_hit_rt = wb_regwrite && (wb_rd == id_rt);
    hazard_rs = id_rs_use && (id_rs != 4'd0) && (cnt_q[id_rs] > {1'b0, wb_hit_rs});
    hazard_rt = id_rt_use && (id_rt != 4'd0) && (cnt_q[id_rt] > {1'b0, wb_hit_rt});
    // A full counter blocks issue even when a WB to that register lands in the
    // same cycle, so the counter can never wrap from 3 back to 0.
    full_rd   = id_wr && (id_rd != 4'd0) && (cnt_q[id_rd] == 2'd3);
    stall     = id_valid && (hazard_rs || hazard_rt || full_rd);
    // A squashed cycle drops the decode instruction without stalling it.
    issue     = id_valid && !stall && !x_kill;
  end

  // Next value of each pending counter. The issue increment and the two
  // decrements (WB and kill) are summed, and the result is clamped to 0..3.
  always_comb begin
    logic [2:0] up;
    logic [2:0] down;
    logic       inc, dec_wb, dec_kill;
    underflow = 1'b0;
    cnt_d[0]  = 2'd0;
    for (int r = 1; r < 16; r++) begin
      inc      = issue && id_wr && (id_rd == r[3:0]);
      dec_wb   = wb_regwrite && (wb_rd == r[3:0]);
      dec_kill = x_kill && x_wr && (x_rd == r[3:0]);
      up       = {1'b0, cnt_q[r]} + {2'b00, inc};
      down     = {2'b00, dec_wb} + {2'b00, dec_kill};
      if (down > up) begin
        cnt_d[r]  = 2'd0;
        underflow = 1'b1;
      end else if ((up - down) > 3'd3) begin
        cnt_d[r] = 2'd3;
      end else begin
        cnt_d[r] = 2'(up - down);
      end
    end
  end

  // Next values of the sticky error flag and the saturating stall counter.
  always_comb begin
    err_d       = err_q || underflow;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers. Reset clears them at once, without waiting for the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) begin
        cnt_q[r] <= 2'd0;
      end
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy is taken directly from the current counter values.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      nonzero[r] = (cnt_q[r] != 2'd0);
    end
    busy = |nonzero;
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard. The expected values were worked out
// by hand from the scoreboard behaviour. Inputs change just after a rising
// edge, and outputs are sampled mid-cycle.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_wr, id_rs_use, id_rt_use;
  logic [3:0]  id_rd, id_rs, id_rt;
  logic        wb_regwrite;
  logic [3:0]  wb_rd;
  logic        x_kill, x_wr;
  logic [3:0]  x_rd;
  logic        stall, busy, err;
  logic [15:0] stall_cnt;

  int n_vec;
  int n_bad;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_wr       (id_wr),
    .id_rd       (id_rd),
    .id_rs       (id_rs),
    .id_rs_use   (id_rs_use),
    .id_rt       (id_rt),
    .id_rt_use   (id_rt_use),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .x_kill      (x_kill),
    .x_wr        (x_wr),
    .x_rd        (x_rd),
    .stall       (stall),
    .busy        (busy),
    .err         (err),
    .stall_cnt   (stall_cnt)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the value is wrong.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive every input to its idle value.
  task automatic idle();
    id_valid = 0; id_wr = 0; id_rd = 0; id_rs = 0; id_rs_use = 0;
    id_rt = 0; id_rt_use = 0; wb_regwrite = 0; wb_rd = 0;
    x_kill = 0; x_wr = 0; x_rd = 0;
  endtask

  // Advance one clock edge, then wait until the outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up a decode that writes register rd.
  task automatic dec_wr(input logic [3:0] rd);
    idle();
    id_valid = 1; id_wr = 1; id_rd = rd;
  endtask

  // Set up a WB write to register rd.
  task automatic wb(input logic [3:0] rd);
    idle();
    wb_regwrite = 1; wb_rd = rd;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle();
    rst_n = 0;
    #12;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1;
    tick();

    // A decode writes r3, then the next decode reads r3 and stalls.
    dec_wr(4'd3); #1;
    check("iss_r3_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle(); id_valid = 1; id_rs = 3; id_rs_use = 1; #1;
    check("raw_r3_stall", {31'd0, stall}, 32'd1);
    check("raw_r3_busy", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();
    check("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);

    // A WB to r3 in the same cycle bypasses the hazard.
    wb_regwrite = 1; wb_rd = 3; #1;
    check("bypass_r3", {31'd0, stall}, 32'd0);
    tick();
    idle(); #1;
    check("r3_cleared_busy", {31'd0, busy}, 32'd0);
    check("stall_cnt_hold", {16'd0, stall_cnt}, 32'd3);

    // Three writes to r5 fill its counter, so a fourth decode stalls.
    for (int i = 0; i < 3; i++) begin
      dec_wr(4'd5); #1;
      check($sformatf("iss_r5_%0d", i), {31'd0, stall}, 32'd0);
      tick();
    end
    dec_wr(4'd5); #1;
    check("full_r5_stall", {31'd0, stall}, 32'd1);
    tick();
    wb_regwrite = 1; wb_rd = 5; #1;
    check("full_r5_wb_stall", {31'd0, stall}, 32'd1);
    tick();
    wb_regwrite = 0; #1;
    check("full_r5_released", {31'd0, stall}, 32'd0);
    check("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
    tick();
    // That decode issued, so r5 holds 3 pending writes again. Drain them.
    for (int i = 0; i < 3; i++) begin
      wb(4'd5); tick();
    end
    idle(); #1;
    check("r5_drained_busy", {31'd0, busy}, 32'd0);
    check("r5_drained_err", {31'd0, err}, 32'd0);

    // An issue and a WB to the same register in the same cycle cancel out.
    dec_wr(4'd4); tick();
    dec_wr(4'd4); wb_regwrite = 1; wb_rd = 4; tick();
    idle(); #1;
    check("r4_inc_dec_busy", {31'd0, busy}, 32'd1);
    wb(4'd4); tick(); idle(); #1;
    check("r4_cleared", {31'd0, busy}, 32'd0);

    // A hazard on the second source, then the same read with a WB bypass.
    dec_wr(4'd6); tick();
    idle(); id_valid = 1; id_rt = 6; id_rt_use = 1; #1;
    check("raw_rt_stall", {31'd0, stall}, 32'd1);
    wb_regwrite = 1; wb_rd = 6; #1;
    check("raw_rt_bypass", {31'd0, stall}, 32'd0);
    tick(); idle(); #1;
    check("r6_cleared", {31'd0, busy}, 32'd0);

    // A killed decode is dropped without a stall and without an increment.
    dec_wr(4'd9); x_kill = 1; #1;
    check("kill_nostall", {31'd0, stall}, 32'd0);
    tick(); idle(); #1;
    check("kill_no_inc", {31'd0, busy}, 32'd0);

    // r7 at 2; a WB and a kill on the same edge take it to 0, and one more WB sets err.
    dec_wr(4'd7); tick(); dec_wr(4'd7); tick();
    wb(4'd7); x_kill = 1; x_wr = 1; x_rd = 7; tick();
    idle(); #1;
    check("r7_double_dec_busy", {31'd0, busy}, 32'd0);
    check("r7_double_dec_err", {31'd0, err}, 32'd0);
    wb(4'd7); tick(); idle(); #1;
    check("r7_underflow_err", {31'd0, err}, 32'd1);
    check("r7_clamped_busy", {31'd0, busy}, 32'd0);
    id_valid = 1; id_rs = 7; id_rs_use = 1; #1;
    check("r7_clamped_nostall", {31'd0, stall}, 32'd0);
    tick();

    // r0 is never tracked.
    dec_wr(4'd0); id_rs = 0; id_rs_use = 1; #1;
    check("r0_nostall", {31'd0, stall}, 32'd0);
    tick(); #1;
    check("r0_nostall2", {31'd0, stall}, 32'd0);
    check("r0_busy", {31'd0, busy}, 32'd0);

    // 70000 stalled cycles saturate the stall counter.
    dec_wr(4'd1); tick();
    idle(); id_valid = 1; id_rs = 1; id_rs_use = 1;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    wb(4'd1); tick(); idle(); #1;

    // Reset asserted between edges clears all state at once.
    dec_wr(4'd2); tick(); dec_wr(4'd2); tick(); idle();
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    #1 rst_n = 0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    id_valid = 1; id_rs = 2; id_rs_use = 1; #1;
    check("async_rst_nostall", {31'd0, stall}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;
    dec_wr(4'd2); tick(); idle(); #1;
    check("post_rst_issue_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
